// File: rtl/csi2tx_req_ack_dest_if.sv
// Request/acknowledge handshake bundle between the source-side toggle
// synchroniser and the destination-side capture block.
//   master : the driver of the request toggle and consumer readiness
//   slave  : the capture block (csi2tx_req_ack_dest)
interface csi2tx_req_ack_dest_if #(
   parameter int DATA_W = 32
);
   logic              req_sync;
   logic [DATA_W-1:0] data_in;
   logic              ack_tgl;
   logic              dst_valid;
   logic [DATA_W-1:0] dst_data;
   logic              dst_ready;

   modport master (
      output req_sync, data_in, dst_ready,
      input  ack_tgl, dst_valid, dst_data
   );

   modport slave (
      input  req_sync, data_in, dst_ready,
      output ack_tgl, dst_valid, dst_data
   );
endinterface

// File: rtl/csi2tx_req_ack_dest.sv
// Destination side of a toggle-based req/ack clock-domain crossing.
// A change on the synchronised request toggle captures the held source word,
// presents it downstream with valid/ready, and on acceptance flips the ack
// toggle back to the source and counts the transfer. Requests arriving while
// a word is pending or during the ACK cool-down cycle are dropped.
// Optional feature: define CSI2TX_REQ_ACK_OVR_CHK_EN to flag dropped requests
// on the sticky err_overrun output (cleared by err_clr); otherwise
// err_overrun is tied low and err_clr is ignored.
module csi2tx_req_ack_dest #(
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   csi2tx_req_ack_dest_if.slave     bus,
   input  logic                     err_clr,
   output logic                     busy,
   output logic [15:0]              xfer_cnt,
   output logic                     err_overrun
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_VALID = 2'd1,
      ST_ACK   = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic              req_d;
   logic              tgl_evt;
   logic              capture;
   logic              handshake;
   logic              lost;
   logic              dst_valid_q;
   logic [DATA_W-1:0] dst_data_q;
   logic              ack_q;
   logic [15:0]       cnt_q;

   assign tgl_evt = bus.req_sync ^ req_d;

   // Next-state and per-edge event decode.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
      state_d   = state_q;
      capture   = 1'b0;
      handshake = 1'b0;
      lost      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tgl_evt) begin
               capture = 1'b1;
               state_d = ST_VALID;
            end
         end
         ST_VALID: begin
            lost = tgl_evt;
            if (bus.dst_ready) begin
               handshake = 1'b1;
               state_d   = ST_ACK;
            end
         end
         ST_ACK: begin
            lost    = tgl_evt;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Request edge history, captured word, ack toggle and transfer counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_d       <= 1'b0;
         dst_valid_q <= 1'b0;
         // NOTE: the data register is reset as well, so dst_data reads zero after reset rather than stale data.
         dst_data_q  <= '0;
         ack_q       <= 1'b0;
         cnt_q       <= 16'h0000;
      end else begin
         req_d <= bus.req_sync;
         if (capture) begin
            dst_data_q  <= bus.data_in;
            dst_valid_q <= 1'b1;
         end
         if (handshake) begin
            dst_valid_q <= 1'b0;
            ack_q       <= ~ack_q;
            cnt_q       <= cnt_q + 16'd1;
         end
      end
   end

`ifdef CSI2TX_REQ_ACK_OVR_CHK_EN
   logic err_q;

   // Sticky overrun flag: a dropped request sets it, err_clr clears it, set has priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       err_q <= 1'b0;
      else if (lost)    err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
   end

   assign err_overrun = err_q;
`else
   logic unused_ovr_sigs;

   assign unused_ovr_sigs = err_clr | lost;
   assign err_overrun     = 1'b0;
`endif

   assign bus.dst_valid = dst_valid_q;
   assign bus.dst_data  = dst_data_q;
   assign bus.ack_tgl   = ack_q;
   assign busy          = (state_q != ST_IDLE);
   assign xfer_cnt      = cnt_q;

endmodule

// File: tb/tb_csi2tx_req_ack_dest.sv
// Self-checking bench for csi2tx_req_ack_dest: directed scenarios followed by
// randomised traffic. A transaction-level model tracks whether a word is
// pending and how many cool-down cycles remain; captured words go into a
// scoreboard queue that a negedge monitor compares and retires on handshake.
module tb_csi2tx_req_ack_dest;

   localparam int DATA_W = 32;
`ifdef CSI2TX_REQ_ACK_OVR_CHK_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        err_clr;
   logic        busy;
   logic [15:0] xfer_cnt;
   logic        err_overrun;

   csi2tx_req_ack_dest_if #(.DATA_W(DATA_W)) bus ();

   csi2tx_req_ack_dest #(.DATA_W(DATA_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .err_clr     (err_clr),
      .busy        (busy),
      .xfer_cnt    (xfer_cnt),
      .err_overrun (err_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DATA_W-1:0] exp_q[$];
   bit          m_req_prev;
   bit          m_holding;
   int          m_cool;
   logic [15:0] m_cnt;
   bit          m_ack;
   bit          m_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_req_prev = 1'b0;
         m_holding  = 1'b0;
         m_cool     = 0;
         m_cnt      = 16'h0000;
         m_ack      = 1'b0;
         m_err      = 1'b0;
         exp_q.delete();
      end else begin
         bit tgl;
         bit dropped;
         tgl        = (bus.req_sync != m_req_prev);
         m_req_prev = bus.req_sync;
         dropped    = 1'b0;
         if (m_holding) begin
            dropped = tgl;
            if (bus.dst_ready) begin
               m_holding = 1'b0;
               m_cnt     = m_cnt + 16'd1;
               m_ack     = ~m_ack;
               m_cool    = 1;
            end
         end else if (m_cool > 0) begin
            dropped = tgl;
            m_cool--;
         end else if (tgl) begin
            exp_q.push_back(bus.data_in);
            m_holding = 1'b1;
         end
         if (OVR_EN) begin
            if (dropped)      m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         check("dst_valid", {31'd0, bus.dst_valid}, {31'd0, m_holding});
         check("busy", {31'd0, busy}, {31'd0, (m_holding || m_cool > 0)});
         check("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, m_cnt});
         check("ack_tgl", {31'd0, bus.ack_tgl}, {31'd0, m_ack});
         check("err_overrun", {31'd0, err_overrun}, {31'd0, m_err});
         if (bus.dst_valid) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
               check("dst_data", bus.dst_data, exp_q[0]);
               if (bus.dst_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [DATA_W-1:0] d);
      bus.data_in  = d;
      bus.req_sync = ~bus.req_sync;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.req_sync  = 1'b0;
      bus.data_in   = '0;
      bus.dst_ready = 1'b0;
      err_clr       = 1'b0;

      // Reset state.
      #2;
      check("rst_valid", {31'd0, bus.dst_valid}, 32'd0);
      check("rst_data", bus.dst_data, 32'd0);
      check("rst_ack", {31'd0, bus.ack_tgl}, 32'd0);
      check("rst_cnt", {16'd0, xfer_cnt}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err", {31'd0, err_overrun}, 32'd0);
      cyc(2);
      rst_n = 1'b1;
      cyc(2);

      // Single transfer with the consumer always ready.
      bus.dst_ready = 1'b1;
      send(32'hA5A5_0001);
      cyc();
      @(negedge clk);
      check("basic_valid", {31'd0, bus.dst_valid}, 32'd1);
      check("basic_data", bus.dst_data, 32'hA5A5_0001);
      cyc();
      @(negedge clk);
      check("basic_ack", {31'd0, bus.ack_tgl}, 32'd1);
      check("basic_cnt", {16'd0, xfer_cnt}, 32'd1);
      cyc();
      @(negedge clk);
      check("basic_busy_low", {31'd0, busy}, 32'd0);
      cyc(2);

      // Consumer stalls for 10 cycles.
      bus.dst_ready = 1'b0;
      send(32'h1234_5678);
      cyc(11);
      bus.dst_ready = 1'b1;
      cyc(4);
      check("stall_cnt", {16'd0, xfer_cnt}, 32'd2);
      check("stall_ack", {31'd0, bus.ack_tgl}, 32'd0);

      // Request while a word is pending is dropped; clear collides with a new drop.
      bus.dst_ready = 1'b0;
      send(32'hCAFE_0003);
      cyc(2);
      send(32'hDEAD_0004);
      cyc();
      @(negedge clk);
      check("ovr_flag", {31'd0, err_overrun}, {31'd0, OVR_EN});
      err_clr = 1'b1;
      send(32'hDEAD_0005);
      cyc();
      @(negedge clk);
      check("ovr_set_wins", {31'd0, err_overrun}, {31'd0, OVR_EN});
      cyc();
      @(negedge clk);
      check("ovr_cleared", {31'd0, err_overrun}, 32'd0);
      err_clr       = 1'b0;
      bus.dst_ready = 1'b1;
      cyc(4);
      check("ovr_cnt", {16'd0, xfer_cnt}, 32'd3);

      // Counter wrap: preload the counter, then one more transfer.
      @(posedge clk);
      #2;
      dut.cnt_q = 16'hFFFF;
      m_cnt     = 16'hFFFF;
      cyc();
      send(32'h0BAD_F00D);
      cyc(4);
      check("wrap_cnt", {16'd0, xfer_cnt}, 32'd0);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(2) == 0) send($urandom);
         else bus.data_in = $urandom;
         bus.dst_ready = ($urandom_range(3) != 0);
         err_clr       = ($urandom_range(7) == 0);
         cyc();
      end
      err_clr = 1'b0;

      // Reset while a word is pending, then release with req_sync high.
      bus.dst_ready = 1'b0;
      bus.req_sync  = 1'b0;
      cyc(4);
      send(32'h7777_0007);
      cyc(2);
      check("pre_rst_valid", {31'd0, bus.dst_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, bus.dst_valid}, 32'd0);
      check("mid_rst_ack", {31'd0, bus.ack_tgl}, 32'd0);
      check("mid_rst_cnt", {16'd0, xfer_cnt}, 32'd0);
      bus.req_sync = 1'b1;
      bus.data_in  = 32'h5A5A_0008;
      cyc();
      rst_n = 1'b1;
      cyc();
      @(negedge clk);
      check("post_rst_valid", {31'd0, bus.dst_valid}, 32'd1);
      check("post_rst_data", bus.dst_data, 32'h5A5A_0008);
      bus.dst_ready = 1'b1;
      cyc(4);
      check("post_rst_cnt", {16'd0, xfer_cnt}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/csi2tx_req_ack_dest.md
CSI2TX_REQ_ACK_DEST -- requirements
Module: csi2tx_req_ack_dest

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of the transferred data word.
REQ-002 clk  input  1  destination-domain clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 req_sync  input  1  request toggle, already double-flop synchronised into clk.
REQ-005 data_in  input  DATA_W  source data; held stable by source from toggle until ack observed.
REQ-006 dst_ready  input  1  downstream consumer ready.
REQ-007 err_clr  input  1  synchronous clear of err_overrun.
REQ-008 dst_valid  output  1  captured word available.
REQ-009 dst_data  output  DATA_W  captured word.
REQ-010 ack_tgl  output  1  acknowledge toggle returned to source domain.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 xfer_cnt  output  16  completed-transfer count.
REQ-013 err_overrun  output  1  sticky protocol-violation flag.

Function
REQ-014 The block SHALL register req_sync into req_d every cycle; toggle event = req_sync XOR req_d.
REQ-015 FSM SHALL have states IDLE, VALID, ACK; reset state IDLE.
REQ-016 IDLE: on toggle event at edge N, data_in SHALL be loaded into dst_data, dst_valid set, state -> VALID; dst_valid high from cycle N+1.
REQ-017 VALID: dst_valid SHALL stay high and dst_data stable until an edge with dst_ready=1.
REQ-018 On that edge, dst_valid SHALL clear, ack_tgl SHALL invert, xfer_cnt SHALL increment by 1, state -> ACK.
REQ-019 ACK: state SHALL return to IDLE on next edge unconditionally; minimum spacing between accepted requests is 3 cycles.
REQ-020 dst_ready while in IDLE or ACK SHALL have no effect.
REQ-021 xfer_cnt SHALL wrap from 16'hFFFF to 16'h0000 without flag.
REQ-022 A toggle event in VALID or ACK SHALL not be captured; req_d still updates, so that request is lost.
REQ-023 Toggle event coinciding with the VALID-to-ACK handshake edge SHALL be treated as per REQ-022 (lost).
REQ-024 dst_data SHALL hold its last value in IDLE and ACK.

Reset
REQ-025 On rst_n low, asynchronously: state IDLE, req_d 0, dst_valid 0, dst_data 0, ack_tgl 0, xfer_cnt 0, err_overrun 0, busy 0.
REQ-026 Reset mid-transfer SHALL abort the transfer without ack toggle; first toggle after release from req_sync=0 baseline is a new request.
REQ-027 req_sync=1 at reset release SHALL be detected as a toggle event on the first edge.

Configuration
REQ-028 Macro CSI2TX_REQ_ACK_OVR_CHK_EN SHALL control overrun detection.
REQ-029 Defined: a lost request per REQ-022/023 SHALL set err_overrun on that edge; err_clr=1 clears it next edge; set wins over simultaneous clear.
REQ-030 Undefined: err_overrun SHALL be tied 0, err_clr ignored; all other behaviour identical.

Verification
REQ-031 Reset, req_sync 0->1 with data_in=32'hA5A5_0001, dst_ready=1 -> dst_valid one cycle after toggle with dst_data=32'hA5A5_0001, ack_tgl 0->1, xfer_cnt=1, busy low 3 cycles after toggle.
REQ-032 Toggle with dst_ready=0 for 10 cycles then 1 -> dst_valid high 10+ cycles, dst_data stable, single ack_tgl flip, xfer_cnt+1.
REQ-033 Second toggle while in VALID (macro defined) -> not captured, err_overrun=1, xfer_cnt +1 only; err_clr pulse -> err_overrun 0; macro undefined -> err_overrun stays 0.
REQ-034 Preload 65535 transfers (or force xfer_cnt=16'hFFFF), one more transfer -> xfer_cnt=16'h0000.
REQ-035 rst_n low while dst_valid=1 -> dst_valid, ack_tgl, xfer_cnt 0 immediately; with req_sync=1 at release -> new capture on first edge.
REQ-036 err_clr and overrun on same edge (macro defined) -> err_overrun=1.
